// File: rtl/cpld_pkg.sv
// Shared constants and enums for the CPLD address decode / register block.
// Pure declarations: no logic, no latency, no flow control.
package cpld_pkg;

  localparam logic [15:0] ELK_PAGED_ROM_SEL    = 16'hFE05;
  localparam logic [15:0] PAGED_ROM_SEL        = 16'hFE30;
  localparam logic [15:0] BPLUS_SHADOW_RAM_SEL = 16'hFE34;

  typedef enum logic [1:0] {
    BEEB   = 2'b00,
    BPLUS  = 2'b01,
    ELK    = 2'b10,
    MASTER = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_STRETCH = 2'b01,
    ST_RELEASE = 2'b10
  } stretch_state_t;

endpackage

// File: rtl/cpld_adr_dec_regs_slow_cycle_fsm.sv
// Host-cycle stretcher: slow_req high for SLOW_CYC clks starting the clk after a trigger.
// Holds the CPU (cpu_rdy=0) from the trigger cycle to the last stretch cycle; retriggers only from IDLE.
module slow_cycle_fsm
  import cpld_pkg::*;
#(
  parameter int SLOW_CYC = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic slow_req,
  output logic cpu_rdy,
  output logic idle
);

  stretch_state_t state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d = ST_STRETCH;
          cnt_d   = 4'(SLOW_CYC - 1);
        end
      end
      ST_STRETCH: begin
        if (cnt_q == 4'd0) state_d = ST_RELEASE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign idle     = (state_q == ST_IDLE);
  assign slow_req = (state_q == ST_STRETCH);
  // The hit cycle itself must already stall the CPU, before the FSM leaves IDLE.
  assign cpu_rdy  = !((state_q == ST_STRETCH) || ((state_q == ST_IDLE) && trig));

endmodule

// File: rtl/cpld_adr_dec_regs.sv
// 65816-to-host address decode, paged-ROM/shadow registers, host address latch and slow-cycle stretch.
// Registers/latch update 1 clk after the qualifying edge; CPU held via cpu_rdy during slow cycles.
// LATCH_ADR_EN defined: bbc_adr holds while lat_en=0; undefined: bbc_adr clears while lat_en=0.
module cpld_adr_dec_regs
  import cpld_pkg::*;
#(
  parameter int ADR_W    = 12,
  parameter int ROMSEL_W = 4,
  parameter int SLOW_CYC = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         cpu_adr,
  input  logic [7:0]          cpu_data,
  input  logic                cpu_rnw,
  input  logic                cpu_vda,
  input  logic [1:0]          j,
  input  logic                lat_en,
  output logic [ADR_W-1:0]    bbc_adr,
  output logic                dec_rom_reg,
  output logic                dec_shadow_reg,
  output logic                dec_fe4x,
  output logic [ROMSEL_W-1:0] rom_sel,
  output logic                shadow_en,
  output logic                slow_req,
  output logic                cpu_rdy
);

  mode_t               mode_q, mode_d;
  logic [ROMSEL_W-1:0] rom_sel_q, rom_sel_d;
  logic                shadow_en_q, shadow_en_d;
  logic [ADR_W-1:0]    bbc_adr_q, bbc_adr_d;
  logic                fsm_idle;
  logic                reg_wr;
  logic                data_unused;

  assign data_unused = ^cpu_data;

  assign dec_rom_reg    = (mode_q == ELK) ? (cpu_adr == ELK_PAGED_ROM_SEL)
                                          : (cpu_adr == PAGED_ROM_SEL);
  assign dec_shadow_reg = ((mode_q == BPLUS) || (mode_q == MASTER)) &&
                          (cpu_adr == BPLUS_SHADOW_RAM_SEL);
  assign dec_fe4x       = (cpu_adr[15:4] == 12'hFE4) || (cpu_adr[15:9] == 7'b1111_110);

  assign reg_wr = cpu_vda && !cpu_rnw && fsm_idle;

  always_comb begin
    mode_d      = rst ? mode_t'(j) : mode_q;
    rom_sel_d   = rom_sel_q;
    shadow_en_d = shadow_en_q;
    if (reg_wr && dec_rom_reg)    rom_sel_d   = cpu_data[ROMSEL_W-1:0];
    if (reg_wr && dec_shadow_reg) shadow_en_d = cpu_data[7];
    if (lat_en) begin
      bbc_adr_d = cpu_adr[ADR_W-1:0];
    end else begin
`ifdef LATCH_ADR_EN
      bbc_adr_d = bbc_adr_q;
`else
      bbc_adr_d = '0;
`endif
    end
  end

  // Mode tracks the jumpers only while in reset, then stays frozen.
  always_ff @(posedge clk) begin
    mode_q <= mode_d;
    if (rst) begin
      rom_sel_q   <= '0;
      shadow_en_q <= 1'b0;
      bbc_adr_q   <= '0;
    end else begin
      rom_sel_q   <= rom_sel_d;
      shadow_en_q <= shadow_en_d;
      bbc_adr_q   <= bbc_adr_d;
    end
  end

  slow_cycle_fsm #(
    .SLOW_CYC (SLOW_CYC)
  ) u_slow_cycle_fsm (
    .clk      (clk),
    .rst      (rst),
    .trig     (cpu_vda && dec_fe4x),
    .slow_req (slow_req),
    .cpu_rdy  (cpu_rdy),
    .idle     (fsm_idle)
  );

  assign rom_sel   = rom_sel_q;
  assign shadow_en = shadow_en_q;
  assign bbc_adr   = bbc_adr_q;

endmodule
